// File: rtl/dlatch_8bit_if.sv
// rtl/dlatch_8bit_if.sv - data/enable in, held data/loaded flag out for dlatch_8bit
interface dlatch_8bit_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] d;
  logic             en;
  logic [WIDTH-1:0] out;
  logic             loaded;

  modport master (
    output d,
    output en,
    input  out,
    input  loaded
  );

  modport slave (
    input  d,
    input  en,
    output out,
    output loaded
  );
endinterface

// File: rtl/dlatch_8bit.sv
// rtl/dlatch_8bit.sv - enable-controlled hold register with async active-low clear
module dlatch_8bit #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic          clk,
  input  logic          reset,
  dlatch_8bit_if.slave  bus
);

  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;
  logic             loaded_q;
  logic             loaded_d;

  always_comb begin
    out_d    = out_q;
    loaded_d = loaded_q;
    if (bus.en) begin
      out_d    = bus.d;
      loaded_d = 1'b1;
    end
  end

  // Reset clears any X on out without waiting for a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q    <= RESET_VALUE;
      loaded_q <= 1'b0;
    end else begin
      out_q    <= out_d;
      loaded_q <= loaded_d;
    end
  end

  assign bus.out    = out_q;
  assign bus.loaded = loaded_q;

endmodule

// File: tb/tb_dlatch_8bit.sv
// tb/tb_dlatch_8bit.sv - directed and random checks of dlatch_8bit
module tb_dlatch_8bit;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  dlatch_8bit_if #(.WIDTH(8)) bus ();

  dlatch_8bit #(.WIDTH(8), .RESET_VALUE(8'h00)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  logic [7:0] hold_d [5];
  logic [7:0] m_out;
  logic       m_loaded;

  initial begin
    n_vec = 0;
    n_err = 0;
    hold_d[0] = 8'h09; hold_d[1] = 8'h63; hold_d[2] = 8'h0D;
    hold_d[3] = 8'h09; hold_d[4] = 8'h63;

    // Reset asserted with en=1, d=0x24
    reset  = 1'b0;
    bus.en = 1'b1;
    bus.d  = 8'h24;
    #2;
    check("rst_out", {8'h00, bus.out}, 16'h0000);
    check("rst_loaded", {15'h0, bus.loaded}, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_clk_out", {8'h00, bus.out}, 16'h0000);
    end

    // Release and track
    neg();
    reset = 1'b1;
    tick();
    check("first_cap_out", {8'h00, bus.out}, 16'h0024);
    check("first_cap_loaded", {15'h0, bus.loaded}, 16'h0001);
    neg();
    bus.d = 8'h81;
    #1;
    check("no_comb_path", {8'h00, bus.out}, 16'h0024);
    tick();
    check("track_81", {8'h00, bus.out}, 16'h0081);

    // Hold while d wanders
    neg();
    bus.en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.d = hold_d[i];
      tick();
      check("hold_81", {8'h00, bus.out}, 16'h0081);
      neg();
    end

    // Async reset mid-hold
    #2;
    reset = 1'b0;
    #1;
    check("midhold_rst_out", {8'h00, bus.out}, 16'h0000);
    check("midhold_rst_loaded", {15'h0, bus.loaded}, 16'h0000);
    neg();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("post_rst_hold_out", {8'h00, bus.out}, 16'h0000);
      check("post_rst_hold_loaded", {15'h0, bus.loaded}, 16'h0000);
    end
    neg();
    bus.en = 1'b1;
    bus.d  = 8'h8D;
    tick();
    check("cap_8d", {8'h00, bus.out}, 16'h008D);
    check("cap_8d_loaded", {15'h0, bus.loaded}, 16'h0001);

    // Reset beats enable
    neg();
    bus.d = 8'h65;
    reset = 1'b0;
    #1;
    check("prio_async", {8'h00, bus.out}, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("prio_out", {8'h00, bus.out}, 16'h0000);
    end
    neg();
    reset = 1'b1;
    tick();
    check("prio_release", {8'h00, bus.out}, 16'h0065);

    // Random regression against an enable-register reference
    m_out    = 8'h65;
    m_loaded = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      neg();
      bus.d  = 8'($urandom);
      bus.en = 1'($urandom);
      reset  = ($urandom_range(0, 15) != 0);
      tick();
      if (!reset) begin
        m_out    = 8'h00;
        m_loaded = 1'b0;
      end else if (bus.en) begin
        m_out    = bus.d;
        m_loaded = 1'b1;
      end
      check("rand_out", {8'h00, bus.out}, {8'h00, m_out});
      check("rand_loaded", {15'h0, bus.loaded}, {15'h0, m_loaded});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
